// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// game_pkg : direction, keycode and step-state types shared by the game blocks
// Rev 1.0
// ============================================================================
package game_pkg;

   typedef enum logic [1:0] {
      DIR_DOWN  = 2'd0,
      DIR_UP    = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_STEP  = 2'd2
   } step_state_t;

   localparam logic [7:0] KEY_W = 8'h1A;
   localparam logic [7:0] KEY_A = 8'h04;
   localparam logic [7:0] KEY_S = 8'h16;
   localparam logic [7:0] KEY_D = 8'h07;

   // Odd quarters of a step show a stride frame; the foot bit picks which one.
   function automatic logic [1:0] walk_frame(input logic [4:0] pix_off,
                                             input logic foot,
                                             input int unsigned tile_px);
      int unsigned q;
      logic [1:0]  frame;
      q     = ({27'd0, pix_off} * 32'd4) / tile_px;
      frame = 2'd0;
      if ((q & 32'd1) != 32'd0) begin
         frame = foot ? 2'd2 : 2'd1;
      end
      return frame;
   endfunction

endpackage
`default_nettype wire

// File: rtl/key_decode.sv
`default_nettype none
// ============================================================================
// key_decode : WASD keycode to {valid, direction}
// Rev 1.0
// ============================================================================
module key_decode
   import game_pkg::*;
(
   input  logic [7:0] i_keycode,
   output logic       o_valid,
   output dir_t       o_dir
);

   always_comb begin
      o_valid = 1'b1;
      o_dir   = DIR_DOWN;
      case (i_keycode)
         KEY_W:   o_dir = DIR_UP;
         KEY_A:   o_dir = DIR_LEFT;
         KEY_S:   o_dir = DIR_DOWN;
         KEY_D:   o_dir = DIR_RIGHT;
         default: o_valid = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/char_step_ctrl.sv
`default_nettype none
// ============================================================================
// char_step_ctrl : tile-step movement controller for the overworld character
// Rev 1.0
// ============================================================================
module char_step_ctrl
   import game_pkg::*;
#(
   parameter int unsigned TILE_PX  = 16,
   parameter int unsigned WALK_PPF = 1,
   parameter int unsigned RUN_PPF  = 2,
   parameter int unsigned MAP_W    = 32,
   parameter int unsigned MAP_H    = 32,
   parameter int unsigned START_X  = 5,
   parameter int unsigned START_Y  = 5
)(
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_tick,
   input  logic       enable,
   input  logic [7:0] keycode,
   input  logic       run_held,
   output logic       coll_req,
   output logic [7:0] coll_x,
   output logic [7:0] coll_y,
   input  logic       coll_ack,
   input  logic       coll_blocked,
   output logic [7:0] tile_x,
   output logic [7:0] tile_y,
   output logic [4:0] pix_off,
   output logic [1:0] direction,
   output logic       charIsMoving,
   output logic       charIsRunning,
   output logic [1:0] charMoveFrame,
   output logic       step_done
);

   localparam logic [5:0] c_TILE_PX  = 6'(TILE_PX);
   localparam logic [5:0] c_WALK_PPF = 6'(WALK_PPF);
   localparam logic [5:0] c_RUN_PPF  = 6'(RUN_PPF);
   localparam logic [7:0] c_MAX_X    = 8'(MAP_W - 1);
   localparam logic [7:0] c_MAX_Y    = 8'(MAP_H - 1);

   step_state_t r_state, w_state_nx;
   dir_t        r_dir, w_dir_nx, w_key_dir;
   logic        w_key_valid;
   logic [7:0]  r_tile_x, r_tile_y, w_tile_x_nx, w_tile_y_nx;
   logic [7:0]  r_coll_x, r_coll_y, w_coll_x_nx, w_coll_y_nx;
   logic [7:0]  w_tgt_x, w_tgt_y;
   logic [4:0]  r_pix_off, w_pix_off_nx;
   logic [5:0]  w_pix_sum;
   logic        r_foot, w_foot_nx, r_run, w_run_nx;
   logic        r_coll_req, w_coll_req_nx, r_step_done, w_step_done_nx;
   logic        r_moving, w_moving_nx, r_running, w_running_nx;
   logic        w_try, w_in_map;
   logic [1:0]  r_frame, w_frame_nx;

   key_decode u_key_decode (
      .i_keycode (keycode),
      .o_valid   (w_key_valid),
      .o_dir     (w_key_dir)
   );

   assign w_pix_sum = {1'b0, r_pix_off} + (r_run ? c_RUN_PPF : c_WALK_PPF);

   always_comb begin
      w_state_nx     = r_state;
      w_dir_nx       = r_dir;
      w_tile_x_nx    = r_tile_x;
      w_tile_y_nx    = r_tile_y;
      w_coll_x_nx    = r_coll_x;
      w_coll_y_nx    = r_coll_y;
      w_coll_req_nx  = r_coll_req;
      w_pix_off_nx   = r_pix_off;
      w_foot_nx      = r_foot;
      w_run_nx       = r_run;
      w_step_done_nx = 1'b0;
      w_try          = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            w_try = frame_tick & enable & w_key_valid;
         end
         ST_CHECK: begin
            if (coll_ack) begin
               w_coll_req_nx = 1'b0;
               if (coll_blocked) begin
                  w_state_nx = ST_IDLE;
               end else begin
                  w_state_nx   = ST_STEP;
                  w_pix_off_nx = 5'd0;
                  w_run_nx     = run_held;
               end
            end
         end
         ST_STEP: begin
            if (frame_tick && enable) begin
               if (w_pix_sum >= c_TILE_PX) begin
                  case (r_dir)
                     DIR_DOWN:  w_tile_y_nx = r_tile_y + 8'd1;
                     DIR_UP:    w_tile_y_nx = r_tile_y - 8'd1;
                     DIR_LEFT:  w_tile_x_nx = r_tile_x - 8'd1;
                     DIR_RIGHT: w_tile_x_nx = r_tile_x + 8'd1;
                  endcase
                  w_pix_off_nx   = 5'd0;
                  w_step_done_nx = 1'b1;
                  w_foot_nx      = ~r_foot;
                  w_state_nx     = ST_IDLE;
                  w_try          = w_key_valid;
               end else begin
                  w_pix_off_nx = w_pix_sum[4:0];
               end
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase

      // Step decision, shared by IDLE and a completing step (chained move).
      w_tgt_x  = w_tile_x_nx;
      w_tgt_y  = w_tile_y_nx;
      w_in_map = 1'b1;
      case (w_key_dir)
         DIR_DOWN:  if (w_tile_y_nx >= c_MAX_Y) w_in_map = 1'b0; else w_tgt_y = w_tile_y_nx + 8'd1;
         DIR_UP:    if (w_tile_y_nx == 8'd0)    w_in_map = 1'b0; else w_tgt_y = w_tile_y_nx - 8'd1;
         DIR_LEFT:  if (w_tile_x_nx == 8'd0)    w_in_map = 1'b0; else w_tgt_x = w_tile_x_nx - 8'd1;
         DIR_RIGHT: if (w_tile_x_nx >= c_MAX_X) w_in_map = 1'b0; else w_tgt_x = w_tile_x_nx + 8'd1;
      endcase

      if (w_try) begin
         w_dir_nx = w_key_dir;
         if (w_in_map) begin
            w_state_nx    = ST_CHECK;
            w_coll_req_nx = 1'b1;
            w_coll_x_nx   = w_tgt_x;
            w_coll_y_nx   = w_tgt_y;
         end
      end

      w_moving_nx  = (w_state_nx == ST_STEP);
      w_running_nx = w_moving_nx & w_run_nx;
      w_frame_nx   = w_moving_nx ? walk_frame(w_pix_off_nx, w_foot_nx, TILE_PX) : 2'd0;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state     <= ST_IDLE;
         r_dir       <= DIR_DOWN;
         r_tile_x    <= 8'(START_X);
         r_tile_y    <= 8'(START_Y);
         r_coll_x    <= 8'd0;
         r_coll_y    <= 8'd0;
         r_coll_req  <= 1'b0;
         r_pix_off   <= 5'd0;
         r_foot      <= 1'b0;
         r_run       <= 1'b0;
         r_step_done <= 1'b0;
         r_moving    <= 1'b0;
         r_running   <= 1'b0;
         r_frame     <= 2'd0;
      end else begin
         r_state     <= w_state_nx;
         r_dir       <= w_dir_nx;
         r_tile_x    <= w_tile_x_nx;
         r_tile_y    <= w_tile_y_nx;
         r_coll_x    <= w_coll_x_nx;
         r_coll_y    <= w_coll_y_nx;
         r_coll_req  <= w_coll_req_nx;
         r_pix_off   <= w_pix_off_nx;
         r_foot      <= w_foot_nx;
         r_run       <= w_run_nx;
         r_step_done <= w_step_done_nx;
         r_moving    <= w_moving_nx;
         r_running   <= w_running_nx;
         r_frame     <= w_frame_nx;
      end
   end

   assign coll_req      = r_coll_req;
   assign coll_x        = r_coll_x;
   assign coll_y        = r_coll_y;
   assign tile_x        = r_tile_x;
   assign tile_y        = r_tile_y;
   assign pix_off       = r_pix_off;
   assign direction     = r_dir;
   assign charIsMoving  = r_moving;
   assign charIsRunning = r_running;
   assign charMoveFrame = r_frame;
   assign step_done     = r_step_done;

endmodule
`default_nettype wire

// File: tb/tb_char_step_ctrl.sv
`default_nettype none
// ============================================================================
// tb_char_step_ctrl : vector table, directed corner sequences, random vs model
// Rev 1.0
// ============================================================================
module tb_char_step_ctrl;

   localparam int TILE = 16;
   localparam int WALK = 1;
   localparam int RUN  = 2;
   localparam int MW   = 32;
   localparam int MH   = 32;
   localparam logic [7:0] K_W = 8'h1A;
   localparam logic [7:0] K_A = 8'h04;
   localparam logic [7:0] K_S = 8'h16;
   localparam logic [7:0] K_D = 8'h07;

   logic       Clk, Reset_n, frame_tick, enable, run_held, coll_ack, coll_blocked;
   logic [7:0] keycode;
   logic       coll_req, charIsMoving, charIsRunning, step_done;
   logic [7:0] coll_x, coll_y, tile_x, tile_y;
   logic [4:0] pix_off;
   logic [1:0] direction, charMoveFrame;

   char_step_ctrl #(
      .TILE_PX(TILE), .WALK_PPF(WALK), .RUN_PPF(RUN),
      .MAP_W(MW), .MAP_H(MH), .START_X(5), .START_Y(5)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .enable(enable),
      .keycode(keycode), .run_held(run_held), .coll_req(coll_req),
      .coll_x(coll_x), .coll_y(coll_y), .coll_ack(coll_ack),
      .coll_blocked(coll_blocked), .tile_x(tile_x), .tile_y(tile_y),
      .pix_off(pix_off), .direction(direction), .charIsMoving(charIsMoving),
      .charIsRunning(charIsRunning), .charMoveFrame(charMoveFrame),
      .step_done(step_done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_fail   = 0;
   bit foot_exp = 1'b0;

   // collision responder state
   int resp_cnt = 0, resp_delay = 0, resp_blk = 0, resp_fixed = 0;
   bit resp_done = 1'b0, resp_rand = 1'b0;

   typedef struct {
      logic [7:0] key;
      logic       run;
      logic       blk;
      logic       exp_req;
      logic [7:0] exp_cx, exp_cy;
      logic [1:0] exp_dir;
      logic [7:0] exp_x, exp_y;
      int         exp_ticks;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic respond();
      coll_ack = 1'b0;
      if (!coll_req) begin
         resp_cnt   = 0;
         resp_done  = 1'b0;
         resp_delay = resp_rand ? int'($urandom_range(2, 0)) : resp_fixed;
      end else if (!resp_done) begin
         if (resp_cnt == resp_delay) begin
            coll_ack     = 1'b1;
            coll_blocked = (resp_blk == 2) ? ($urandom_range(3, 0) == 0) : (resp_blk == 1);
            resp_done    = 1'b1;
         end
         resp_cnt++;
      end
   endtask

   task automatic cyc();
      @(posedge Clk);
      @(negedge Clk);
      respond();
   endtask

   task automatic do_reset();
      Reset_n = 1'b0; frame_tick = 1'b0; enable = 1'b1; keycode = 8'h00;
      run_held = 1'b0; coll_ack = 1'b0; coll_blocked = 1'b0;
      resp_rand = 1'b0; resp_blk = 0; resp_fixed = 0;
      foot_exp = 1'b0;
      cyc(); cyc();
      Reset_n = 1'b1;
      cyc();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_tile_x"}, tile_x, 5);
      check({tag, "_tile_y"}, tile_y, 5);
      check({tag, "_pix"}, pix_off, 0);
      check({tag, "_dir"}, direction, 0);
      check({tag, "_moving"}, charIsMoving, 0);
      check({tag, "_running"}, charIsRunning, 0);
      check({tag, "_frame"}, charMoveFrame, 0);
      check({tag, "_done"}, step_done, 0);
      check({tag, "_req"}, coll_req, 0);
      check({tag, "_cx"}, coll_x, 0);
      check({tag, "_cy"}, coll_y, 0);
   endtask

   function automatic int exp_frame(input int pix);
      int q;
      q = pix * 4 / TILE;
      return (q % 2 == 1) ? (foot_exp ? 2 : 1) : 0;
   endfunction

   task automatic run_vec(input vec_t v);
      int ticks, ppf;
      bit done;
      ppf = v.run ? RUN : WALK;
      keycode = v.key; run_held = v.run; resp_blk = v.blk ? 1 : 0; enable = 1'b1;
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0; keycode = 8'h00;
      check("accept_req", coll_req, v.exp_req);
      check("accept_dir", direction, v.exp_dir);
      if (v.exp_req) begin
         check("coll_x", coll_x, v.exp_cx);
         check("coll_y", coll_y, v.exp_cy);
      end
      cyc();
      check("req_after_ack", coll_req, 0);
      cyc();
      check("moving_start", charIsMoving, v.exp_ticks > 0);
      if (v.exp_ticks > 0) begin
         ticks = 0; done = 1'b0;
         while (!done && ticks < 40) begin
            frame_tick = 1'b1; cyc(); frame_tick = 1'b0; ticks++;
            if (step_done) begin
               done = 1'b1;
               foot_exp = !foot_exp;
            end else begin
               check("pix_off", pix_off, ticks * ppf);
               check("running", charIsRunning, v.run);
               check("move_frame", charMoveFrame, exp_frame(ticks * ppf));
            end
            cyc();
            if (done) check("done_pulse", step_done, 0);
            cyc();
         end
         check("step_ticks", ticks, v.exp_ticks);
      end
      check("end_tile_x", tile_x, v.exp_x);
      check("end_tile_y", tile_y, v.exp_y);
      check("end_dir", direction, v.exp_dir);
      check("end_moving", charIsMoving, 0);
   endtask

   // ---------------- behavioural reference model ----------------
   // mode: 0 standing, 1 awaiting lookup, 2 walking between tiles
   int m_mode, m_x, m_y, m_dir, m_foot, m_run, m_ticks, m_req, m_cx, m_cy, m_done;

   function automatic int key_dir(input logic [7:0] k);
      if (k == K_S) return 0;
      if (k == K_W) return 1;
      if (k == K_A) return 2;
      if (k == K_D) return 3;
      return -1;
   endfunction

   function automatic int dx(input int d);
      return (d == 2) ? -1 : (d == 3) ? 1 : 0;
   endfunction

   function automatic int dy(input int d);
      return (d == 0) ? 1 : (d == 1) ? -1 : 0;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_x = 5; m_y = 5; m_dir = 0; m_foot = 0; m_run = 0;
      m_ticks = 0; m_req = 0; m_cx = 0; m_cy = 0; m_done = 0;
   endtask

   task automatic model_step(input bit ft, input bit en, input logic [7:0] k,
                             input bit run, input bit ack, input bit blk);
      int kd, tx, ty, ppf;
      bit try_move;
      kd = key_dir(k);
      ppf = m_run ? RUN : WALK;
      m_done = 0;
      try_move = 1'b0;
      if (m_mode == 0) begin
         try_move = ft && en && (kd >= 0);
      end else if (m_mode == 1) begin
         if (ack) begin
            m_req = 0;
            if (blk) m_mode = 0;
            else begin m_mode = 2; m_ticks = 0; m_run = run; end
         end
      end else if (ft && en) begin
         m_ticks++;
         if (m_ticks * ppf >= TILE) begin
            m_x += dx(m_dir); m_y += dy(m_dir);
            m_ticks = 0; m_done = 1; m_foot = 1 - m_foot; m_mode = 0;
            try_move = (kd >= 0);
         end
      end
      if (try_move) begin
         m_dir = kd;
         tx = m_x + dx(kd);
         ty = m_y + dy(kd);
         if (tx >= 0 && tx < MW && ty >= 0 && ty < MH) begin
            m_mode = 1; m_req = 1; m_cx = tx; m_cy = ty;
         end
      end
   endtask

   task automatic model_check();
      int pix, frm;
      pix = m_ticks * (m_run ? RUN : WALK);
      frm = 0;
      if (m_mode == 2 && ((pix * 4 / TILE) % 2 == 1)) frm = m_foot ? 2 : 1;
      check("rnd_tile_x", tile_x, m_x);
      check("rnd_tile_y", tile_y, m_y);
      check("rnd_pix", pix_off, pix);
      check("rnd_dir", direction, m_dir);
      check("rnd_moving", charIsMoving, m_mode == 2);
      check("rnd_running", charIsRunning, (m_mode == 2) && (m_run != 0));
      check("rnd_frame", charMoveFrame, frm);
      check("rnd_done", step_done, m_done);
      check("rnd_req", coll_req, m_req);
      if (m_req != 0) begin
         check("rnd_cx", coll_x, m_cx);
         check("rnd_cy", coll_y, m_cy);
      end
   endtask

   function automatic logic [7:0] pick_key(input int i);
      case (i)
         0: return K_W;
         1: return K_A;
         2: return K_S;
         3: return K_D;
         4: return 8'h2C;
         default: return 8'h00;
      endcase
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      int ticks, dones, x;
      bit done;
      vec_t v;

      do_reset();
      check_reset_vals("reset");

      //          key   run   blk   req   cx     cy     dir   x      y      ticks
      vecs[0] = '{K_D,  1'b0, 1'b0, 1'b1, 8'd6,  8'd5,  2'd3, 8'd6,  8'd5,  16};
      vecs[1] = '{K_D,  1'b1, 1'b0, 1'b1, 8'd7,  8'd5,  2'd3, 8'd7,  8'd5,  8};
      vecs[2] = '{K_A,  1'b0, 1'b1, 1'b1, 8'd6,  8'd5,  2'd2, 8'd7,  8'd5,  0};
      vecs[3] = '{K_W,  1'b0, 1'b0, 1'b1, 8'd7,  8'd4,  2'd1, 8'd7,  8'd4,  16};
      vecs[4] = '{K_S,  1'b1, 1'b0, 1'b1, 8'd7,  8'd5,  2'd0, 8'd7,  8'd5,  8};
      vecs[5] = '{8'h2C,1'b0, 1'b0, 1'b0, 8'd0,  8'd0,  2'd0, 8'd7,  8'd5,  0};
      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // run to the left map edge, then a further left press only turns
      for (int s = 0; s < 7; s++) begin
         x = 7 - s;
         v = '{K_A, 1'b1, 1'b0, 1'b1, 8'(x - 1), 8'd5, 2'd2, 8'(x - 1), 8'd5, 8};
         run_vec(v);
      end
      keycode = K_S; frame_tick = 1'b1; cyc(); frame_tick = 1'b0; keycode = 8'h00;
      cyc(); cyc(); cyc(); cyc();
      for (int t = 0; t < 16; t++) begin frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc(); end
      check("edge_turn_down_y", tile_y, 6);
      v = '{K_A, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 2'd2, 8'd0, 8'd6, 0};
      run_vec(v);

      // chained steps with S held
      do_reset();
      keycode = K_S; run_held = 1'b0; enable = 1'b1;
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      check("chain_first_req", coll_req, 1);
      cyc(); cyc();
      ticks = 0; dones = 0;
      while (dones < 2 && ticks < 40) begin
         if (ticks == 31) keycode = 8'h00;
         frame_tick = 1'b1; cyc(); frame_tick = 1'b0; ticks++;
         if (step_done) begin
            dones++;
            foot_exp = !foot_exp;
            check("chain_done_tick", ticks, 16 * dones);
            if (dones == 1) begin
               check("chain_req_on_done", coll_req, 1);
               check("chain_cy", coll_y, 7);
               check("chain_mid_y", tile_y, 6);
            end
         end else if (ticks % 16 == 4) begin
            check("chain_frame", charMoveFrame, exp_frame(4));
         end
         cyc(); cyc();
      end
      check("chain_dones", dones, 2);
      check("chain_end_y", tile_y, 7);
      check("chain_end_moving", charIsMoving, 0);
      check("chain_end_req", coll_req, 0);

      // enable drops for 5 ticks mid-step
      keycode = K_D; frame_tick = 1'b1; cyc(); frame_tick = 1'b0; keycode = 8'h00;
      cyc(); cyc();
      ticks = 0; done = 1'b0;
      while (!done && ticks < 60) begin
         enable = !(ticks >= 6 && ticks < 11);
         frame_tick = 1'b1; cyc(); frame_tick = 1'b0; ticks++;
         if (step_done) done = 1'b1;
         else if (!enable) check("frozen_pix", pix_off, 6);
         cyc(); cyc();
      end
      enable = 1'b1;
      check("enable_gap_ticks", ticks, 21);
      check("enable_gap_x", tile_x, 6);

      // asynchronous reset mid-step at pix_off=7
      keycode = K_A; frame_tick = 1'b1; cyc(); frame_tick = 1'b0; keycode = 8'h00;
      cyc(); cyc();
      for (int t = 0; t < 7; t++) begin frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc(); end
      check("pre_reset_pix", pix_off, 7);
      Reset_n = 1'b0; #1;
      check_reset_vals("async_step");
      cyc(); Reset_n = 1'b1; cyc();

      // asynchronous reset mid-handshake
      resp_fixed = 2;
      keycode = K_D; frame_tick = 1'b1; cyc(); frame_tick = 1'b0; keycode = 8'h00;
      check("hs_req", coll_req, 1);
      Reset_n = 1'b0; #1;
      check_reset_vals("async_hs");
      cyc(); cyc(); Reset_n = 1'b1; cyc();
      resp_fixed = 0;

      // randomized traffic against the reference model
      do_reset();
      model_reset();
      resp_rand = 1'b1; resp_blk = 2;
      for (int i = 0; i < 3000; i++) begin
         model_check();
         frame_tick = ($urandom_range(2, 0) == 0);
         enable     = ($urandom_range(7, 0) != 0);
         keycode    = pick_key(int'($urandom_range(5, 0)));
         run_held   = $urandom_range(1, 0) == 1;
         model_step(frame_tick, enable, keycode, run_held, coll_ack, coll_blocked);
         cyc();
      end
      model_check();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/char_step_ctrl.md
# char_step_ctrl

Tile-step movement controller for the player character in the main-game state. Turns direction keycodes into whole-tile steps on the overworld grid, querying the map collision lookup before each step. Advances the sub-tile pixel offset once per video frame. Drives the facing, walk-frame and moving/running flags consumed by the character sprite renderer.

## Interface
Parameters:
- TILE_PX, 16: pixels per tile step; power of two, at most 16.
- WALK_PPF, 1: pixels advanced per frame while walking.
- RUN_PPF, 2: pixels advanced per frame while running. TILE_PX must be divisible by both WALK_PPF and RUN_PPF.
- MAP_W, 32: map width in tiles.
- MAP_H, 32: map height in tiles.
- START_X, 5: tile x after reset.
- START_Y, 5: tile y after reset.

Ports:
- Clk, in, 1: system clock.
- Reset_n, in, 1: asynchronous, active-low reset.
- frame_tick, in, 1: one-Clk pulse per frame, already synchronised from VGA_VS.
- enable, in, 1: high while the game FSM is in draw_main_game.
- keycode, in, 8: current USB keycode.
- run_held, in, 1: run button held.
- coll_req, out, 1: collision lookup request.
- coll_x, out, 8: target tile x, valid while coll_req is high.
- coll_y, out, 8: target tile y, valid while coll_req is high.
- coll_ack, in, 1: lookup result is valid this cycle.
- coll_blocked, in, 1: target tile is impassable; sampled only with coll_ack.
- tile_x, out, 8: current tile x.
- tile_y, out, 8: current tile y.
- pix_off, out, 5: pixels travelled into the current step.
- direction, out, 2: facing; 0 down, 1 up, 2 left, 3 right.
- charIsMoving, out, 1: high in STEP.
- charIsRunning, out, 1: high in STEP when the step was latched as a run.
- charMoveFrame, out, 2: walk-cycle sprite frame, 0..2.
- step_done, out, 1: one-Clk pulse when a step completes.

## Operation
- Key map: W 8'h1A → up, A 8'h04 → left, S 8'h16 → down, D 8'h07 → right. Any other keycode means no key.
- State machine: IDLE, CHECK, STEP.
- IDLE:
  - Acts only when frame_tick, enable and a direction key are all present.
  - Sets direction to the key's direction.
  - If the target tile is outside 0..MAP_W-1 or 0..MAP_H-1, the character turns only and stays in IDLE.
  - Otherwise goes to CHECK with coll_x/coll_y set to the target tile.
- CHECK:
  - coll_req is held high and coll_x/coll_y are held stable until coll_ack.
  - The handshake always completes, even if enable drops.
  - On coll_ack with coll_blocked=1: go to IDLE; position is unchanged.
  - On coll_ack with coll_blocked=0: go to STEP, set pix_off=0, latch run mode from run_held.
- STEP:
  - On each frame_tick while enable is high, pix_off increases by PPF (RUN_PPF if run mode was latched, else WALK_PPF).
  - When pix_off+PPF reaches TILE_PX: tile_x/tile_y move one tile in direction, pix_off=0, step_done pulses, and the foot bit toggles.
  - Chaining: on that same tick, if a direction key is held and enable is high, apply the IDLE decision immediately (next state is CHECK or IDLE). There is no idle frame between steps.
  - enable low freezes pix_off; the step resumes when enable returns.
- charMoveFrame:
  - 0 outside STEP.
  - In STEP, q = pix_off·4/TILE_PX. q=0 or 2 → 0; q=1 or 3 → (foot ? 2 : 1).
- Run mode is constant for the whole step; run_held changes take effect on the next step.

## Timing
- Reset values:
  - IDLE; tile_x=START_X, tile_y=START_Y.
  - pix_off=0, direction=0, foot=0.
  - All flags, coll_req and step_done low; coll_x=coll_y=0.
- All outputs are registered.
- coll_req rises the Clk after the accepting frame_tick.
- coll_req falls the Clk after coll_ack. An ack arriving in the first cycle of coll_req is legal.
- A frame_tick during CHECK is ignored. It is not queued.
- An unblocked step takes exactly TILE_PX/PPF frame_ticks after entering STEP: 16 when walking, 8 when running, at default parameters.
- step_done and the tile_x/tile_y update occur in the same Clk as the completing frame_tick.
- Reset_n asserted mid-step or mid-handshake returns all state to reset values immediately. The collision responder must tolerate an abandoned request.

## Structure
- Shared package game_pkg:
  - Direction enum (DIR_DOWN=0, DIR_UP=1, DIR_LEFT=2, DIR_RIGHT=3).
  - KEY_W/A/S/D constants.
  - Step state enum.
- Sub-module key_decode: combinational keycode → {valid, dir[1:0]}. Also reusable by gameFSM.

## Test plan
- Reset at (5,5), then hold D 8'h07 for 16 frame_ticks with the ack returned unblocked one cycle after req → coll_x=6, coll_y=5; tile_x becomes 6 on the 16th tick; one step_done pulse; charMoveFrame sequence 0,1,0,1 per quarter.
- Same stimulus with run_held=1 → step completes on the 8th tick; charIsRunning high throughout.
- A held with coll_blocked=1 → direction=2; no step; tile_x unchanged; return to IDLE.
- At tile_x=0, press A → direction=2; coll_req never asserted.
- Hold S for 32 ticks → two consecutive steps with no gap; CHECK entered on the completion tick; second step uses charMoveFrame 2 (foot toggled).
- Drop enable for 5 ticks mid-step → pix_off frozen; completion delayed by 5 ticks. Pulse Reset_n low at pix_off=7 → immediately back to (5,5), IDLE, all flags low.
